pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges four event sources into one consistent set of per-stage write enables and bubble/flush controls:
  - load-use hazard indication;
  - taken branch resolved in EX;
  - multi-cycle MUL/DIV handshake;
  - data-memory wait.
- Owns the MUL/DIV wait FSM and its timeout watchdog.
- Sits beside the hazard detection unit; drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- MD_TIMEOUT, 64: max MD_WAIT cycles before forced release.
- CNT_W, 7: width of the MD_WAIT cycle counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- ld_use_hazard  in  1  load-use hazard from the hazard detection unit.
- branch_taken_ex  in  1  taken branch/jump resolved in EX.
- md_op_ex  in  1  MUL/DIV instruction currently in EX.
- md_done  in  1  MUL/DIV unit result valid (level, held until consumed).
- dmem_wait  in  1  data memory not ready for the instruction in MEM.
- clr_err  in  1  clears md_timeout.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- idex_write  out  1  ID/EX load enable.
- exmem_write  out  1  EX/MEM load enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_bubble  out  1  ID/EX loads zeroed controls.
- exmem_bubble  out  1  EX/MEM loads zeroed controls.
- memwb_bubble  out  1  MEM/WB loads zeroed controls.
- md_req  out  1  one-cycle start pulse to the MUL/DIV unit.
- md_timeout  out  1  sticky watchdog error.
- ctrl_state  out  2  current FSM state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Output timing: all stage controls are Mealy outputs from the current state and current inputs, combinational in the same cycle.
- Reset state:
  - state=RUN, MD_WAIT counter=0, md_timeout=0;
  - while rst_n=0: all *_write=0, all bubbles/flush=0, md_req=0.
- Default in RUN with no events: all *_write=1, all bubbles/flush=0, md_req=0.
- States: RUN=2'b00, MD_WAIT=2'b01, MD_HOLD=2'b10. 2'b11 is illegal and recovers to RUN on the next clock.
- RUN priority order (highest first):
  1. dmem_wait: pc/ifid/idex/exmem_write=0, memwb_bubble=1. Stay RUN. All lower events are ignored this cycle.
  2. md_op_ex:
     - md_req=1 for one cycle;
     - pc/ifid/idex_write=0, exmem_bubble=1;
     - counter cleared; next state MD_WAIT.
  3. branch_taken_ex: pc_write=1, ifid_flush=1, idex_bubble=1. ld_use_hazard is ignored because the ID instruction is squashed.
  4. ld_use_hazard: pc_write=0, ifid_write=0, idex_bubble=1. Exactly one bubble per hazard assertion cycle.
- MD_WAIT:
  - pc/ifid/idex_write=0, exmem_bubble=1;
  - counter increments and saturates at MD_TIMEOUT;
  - md_op_ex, branch_taken_ex and ld_use_hazard are ignored.
  - md_done and !dmem_wait: release. All writes=1, no bubbles; EX/MEM captures the result. Next state RUN.
  - md_done and dmem_wait: next state MD_HOLD (done is latched).
  - dmem_wait with no done: additionally exmem_write=0, memwb_bubble=1, exmem_bubble=0.
  - counter==MD_TIMEOUT-1 without md_done: set md_timeout, release as if done, go RUN.
- MD_HOLD:
  - freeze as in MD_WAIT plus the dmem_wait rule;
  - when dmem_wait=0: release exactly as on md_done, go RUN.
- md_req never asserts outside the RUN→MD_WAIT transition cycle.
- md_timeout is set by the watchdog and cleared only by clr_err or reset. Set wins if both occur in the same cycle.
- Reset mid-MD_WAIT: immediate return to RUN. Keeping the MUL/DIV unit consistent is the unit's own reset responsibility.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, two extra output ports exist, each 32 bits, saturating at all-ones and cleared by reset:
  - stall_cnt: increments on every cycle pc_write=0 with rst_n=1;
  - flush_cnt: increments on every cycle ifid_flush=1.
- When undefined: neither port nor the counter logic exists; behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding constants RUN, MD_WAIT, MD_HOLD;
  - the 2-bit state typedef;
  - the default MD_TIMEOUT.
- One natural sub-module: sat_counter (parameterised width, enable, synchronous clear, saturate). Used for the MD_WAIT counter and the optional performance counters.

Test Plan:
- Reset then idle: rst_n low 3 cycles → all writes 0. After release → all writes 1, ctrl_state=00.
- ld_use_hazard=1 for 1 cycle in RUN → pc_write=0, ifid_write=0, idex_bubble=1 that cycle only; state stays 00.
- branch_taken_ex=1 and ld_use_hazard=1 in the same cycle → pc_write=1, ifid_flush=1, idex_bubble=1.
- md_op_ex=1, md_done after 5 cycles:
  - md_req pulses once;
  - ctrl_state=01 for 5 cycles;
  - release cycle has all writes=1, then state 00.
- md_done coincides with dmem_wait=1 for 2 cycles:
  - state goes 01→10, held 2 cycles with exmem_write=0, memwb_bubble=1;
  - release when dmem_wait drops.
- md_done never asserted with MD_TIMEOUT=8:
  - md_timeout=1 after 8 cycles, state 00;
  - clr_err pulse → md_timeout=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding and watchdog default.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_WAIT = 2'b01,
        MD_HOLD = 2'b10,
        ILLEGAL = 2'b11
    } ctrl_state_t;

    localparam int MD_TIMEOUT_DEF = 64;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over enable.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != MAX)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, owning the MUL/DIV wait FSM and watchdog.
// Optional 32-bit stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_use_hazard,
    input  logic        branch_taken_ex,
    input  logic        md_op_ex,
    input  logic        md_done,
    input  logic        dmem_wait,
    input  logic        clr_err,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        memwb_bubble,
    output logic        md_req,
    output logic        md_timeout,
    output logic [1:0]  ctrl_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    ctrl_state_t      state, state_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic             cnt_clr;
    logic             to_hit;
    logic             done_eff;

    assign ctrl_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    sat_counter #(
        .W   (CNT_W),
        .MAX (CNT_W'(MD_TIMEOUT))
    ) u_wd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == MD_WAIT),
        .clr   (cnt_clr),
        .cnt   (wd_cnt)
    );

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        md_req       = 1'b0;
        cnt_clr      = 1'b0;
        to_hit       = 1'b0;
        done_eff     = 1'b0;
        state_nxt    = state;
        case (state)
            RUN: begin
                if (dmem_wait) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                end else if (md_op_ex) begin
                    md_req       = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    cnt_clr      = 1'b1;
                    state_nxt    = MD_WAIT;
                end else if (branch_taken_ex) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (ld_use_hazard) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MD_WAIT: begin
                // A watchdog expiry is handled exactly like a real completion.
                to_hit   = (wd_cnt == CNT_W'(MD_TIMEOUT - 1)) && !md_done;
                done_eff = md_done || to_hit;
                if (done_eff && !dmem_wait) begin
                    state_nxt = RUN;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_write = 1'b0;
                    if (dmem_wait) begin
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                        if (done_eff)
                            state_nxt = MD_HOLD;
                    end else begin
                        exmem_bubble = 1'b1;
                    end
                end
            end
            MD_HOLD: begin
                if (!dmem_wait) begin
                    state_nxt = RUN;
                end else begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                end
            end
            default: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                state_nxt   = RUN;
            end
        endcase
        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b0;
            exmem_bubble = 1'b0;
            memwb_bubble = 1'b0;
            md_req       = 1'b0;
        end
    end

    // Set has priority over clear so a simultaneous expiry is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            md_timeout <= 1'b0;
        else if (to_hit)
            md_timeout <= 1'b1;
        else if (clr_err)
            md_timeout <= 1'b0;
    end

`ifdef PIPE_PERF_CNT_EN
    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!pc_write && rst_n),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(32)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_flush),
        .clr   (1'b0),
        .cnt   (flush_cnt)
    );
`endif

endmodule
